// File: rtl/wb_arbiter.sv
// Two-master, one-slave Wishbone arbiter.
// Master I is the instruction fetch stage and master D is the memory stage.
// The arbiter owns the shared slave port for one transfer at a time and
// re-arbitrates after each ack or err. Ties go round-robin on the last owner.
// A watchdog turns a hung slave into an err for the owning master.
module wb_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    // master I (fetch)
    input  logic        wb_instr_cyc_i,
    input  logic        wb_instr_stb_i,
    input  logic        wb_instr_we_i,
    input  logic [3:0]  wb_instr_sel_i,
    input  logic [29:0] wb_instr_adr_i,
    input  logic [31:0] wb_instr_dat_mosi_i,
    output logic [31:0] wb_instr_dat_miso_o,
    output logic        wb_instr_ack_o,
    output logic        wb_instr_err_o,
    // master D (memory stage)
    input  logic        wb_data_cyc_i,
    input  logic        wb_data_stb_i,
    input  logic        wb_data_we_i,
    input  logic [3:0]  wb_data_sel_i,
    input  logic [29:0] wb_data_adr_i,
    input  logic [31:0] wb_data_dat_mosi_i,
    output logic [31:0] wb_data_dat_miso_o,
    output logic        wb_data_ack_o,
    output logic        wb_data_err_o,
    // shared slave port
    output logic        wb_mem_cyc_o,
    output logic        wb_mem_stb_o,
    output logic        wb_mem_we_o,
    output logic [3:0]  wb_mem_sel_o,
    output logic [29:0] wb_mem_adr_o,
    output logic [31:0] wb_mem_dat_mosi_o,
    input  logic [31:0] wb_mem_dat_miso_i,
    input  logic        wb_mem_ack_i,
    input  logic        wb_mem_err_i,
    // status
    output logic [1:0]  grant_out,
    output logic        timeout_out
);

    // The state encoding is the one-hot grant itself, so grant_out is simply the register.
    localparam logic [1:0] IDLE    = 2'b00;
    localparam logic [1:0] GRANT_I = 2'b01;
    localparam logic [1:0] GRANT_D = 2'b10;

    localparam int unsigned     CNT_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);
    localparam bit              WDOG_EN = (TIMEOUT_CYCLES != 0);

    logic [1:0]       state_q, state_d;
    logic             last_d_q, last_d_d;   // 1 = D owned the last completed transfer
    logic [CNT_W-1:0] wdog_q, wdog_d;

    logic             req_i, req_d;
    logic             own_cyc, own_stb, own_we;
    logic [3:0]       own_sel;
    logic [29:0]      own_adr;
    logic [31:0]      own_dat;
    logic             granted, live, resp, fire, done;

    // Choose an owner from the current requests. On a tie, the master that did not go last wins.
    function automatic logic [1:0] arbitrate(input logic ri, input logic rd, input logic last_was_d);
        if (ri && rd)  return last_was_d ? GRANT_I : GRANT_D;
        else if (ri)   return GRANT_I;
        else if (rd)   return GRANT_D;
        else           return IDLE;
    endfunction

    assign req_i = wb_instr_cyc_i & wb_instr_stb_i;
    assign req_d = wb_data_cyc_i  & wb_data_stb_i;

    // Select the bus signals of the current owner. Idle drives all zeros.
    always_comb begin
        // NOTE: every signal gets a default first so that no path leaves it unassigned and infers a latch.
        own_cyc = 1'b0;
        own_stb = 1'b0;
        own_we  = 1'b0;
        own_sel = '0;
        own_adr = '0;
        own_dat = '0;
        case (state_q)
            GRANT_I: begin
                own_cyc = wb_instr_cyc_i;
                own_stb = wb_instr_stb_i;
                own_we  = wb_instr_we_i;
                own_sel = wb_instr_sel_i;
                own_adr = wb_instr_adr_i;
                own_dat = wb_instr_dat_mosi_i;
            end
            GRANT_D: begin
                own_cyc = wb_data_cyc_i;
                own_stb = wb_data_stb_i;
                own_we  = wb_data_we_i;
                own_sel = wb_data_sel_i;
                own_adr = wb_data_adr_i;
                own_dat = wb_data_dat_mosi_i;
            end
            default: ;
        endcase
    end

    // A transfer is live while the owner still holds cyc. It ends on a slave response or a watchdog abort.
    assign granted = (state_q != IDLE);
    assign live    = granted & own_cyc;
    assign resp    = wb_mem_ack_i | wb_mem_err_i;
    assign fire    = WDOG_EN && live && own_stb && !resp && (wdog_q == CNT_MAX);
    assign done    = live & (resp | fire);

    // Slave-side outputs. An abort drops cyc/stb in the same cycle it fires.
    assign wb_mem_cyc_o      = live & ~fire;
    assign wb_mem_stb_o      = live & own_stb & ~fire;
    assign wb_mem_we_o       = own_we;
    assign wb_mem_sel_o      = own_sel;
    assign wb_mem_adr_o      = own_adr;
    assign wb_mem_dat_mosi_o = own_dat;

    // Master-side outputs. Responses reach only a live owner, so late acks are swallowed.
    assign wb_instr_dat_miso_o = wb_mem_dat_miso_i;
    assign wb_data_dat_miso_o  = wb_mem_dat_miso_i;
    assign wb_instr_ack_o      = (state_q == GRANT_I) & live & wb_mem_ack_i;
    assign wb_instr_err_o      = (state_q == GRANT_I) & live & (wb_mem_err_i | fire);
    assign wb_data_ack_o       = (state_q == GRANT_D) & live & wb_mem_ack_i;
    assign wb_data_err_o       = (state_q == GRANT_D) & live & (wb_mem_err_i | fire);
    assign grant_out           = state_q;
    assign timeout_out         = fire;

    // Next owner, round-robin history and watchdog count.
    always_comb begin
        state_d  = state_q;
        last_d_d = last_d_q;
        wdog_d   = wdog_q;
        if (!granted) begin
            state_d = arbitrate(req_i, req_d, last_d_q);
            wdog_d  = '0;
        end else if (!own_cyc) begin
            // The owner abandoned its cycle, so only the other master may take the bus now.
            state_d = arbitrate(req_i & (state_q != GRANT_I), req_d & (state_q != GRANT_D), last_d_q);
            wdog_d  = '0;
        end else if (done) begin
            last_d_d = (state_q == GRANT_D);
            state_d  = arbitrate(req_i, req_d, last_d_d);
            wdog_d   = '0;
        end else if (WDOG_EN && own_stb && (wdog_q != CNT_MAX)) begin
            wdog_d = wdog_q + CNT_W'(1);
        end
    end

    // State registers. Reset returns to idle with D as the last owner, so I wins the first tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            last_d_q <= 1'b1;
            wdog_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments make all three registers update together from pre-edge values.
            state_q  <= state_d;
            last_d_q <= last_d_d;
            wdog_q   <= wdog_d;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus a randomized
// run checked against a transaction-level reference model.
module tb_wb_arbiter;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_cyc, i_stb, i_we, d_cyc, d_stb, d_we;
    logic [3:0]  i_sel, d_sel;
    logic [29:0] i_adr, d_adr;
    logic [31:0] i_dmo, d_dmo;
    logic [31:0] i_dmi, d_dmi;
    logic        i_ack, i_err, d_ack, d_err;
    logic        m_cyc, m_stb, m_we;
    logic [3:0]  m_sel;
    logic [29:0] m_adr;
    logic [31:0] m_dmo, m_dmi;
    logic        m_ack, m_err;
    logic [1:0]  grant;
    logic        tmo;

    int checks   = 0;
    int failures = 0;

    wb_arbiter #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst),
        .wb_instr_cyc_i(i_cyc), .wb_instr_stb_i(i_stb), .wb_instr_we_i(i_we),
        .wb_instr_sel_i(i_sel), .wb_instr_adr_i(i_adr), .wb_instr_dat_mosi_i(i_dmo),
        .wb_instr_dat_miso_o(i_dmi), .wb_instr_ack_o(i_ack), .wb_instr_err_o(i_err),
        .wb_data_cyc_i(d_cyc), .wb_data_stb_i(d_stb), .wb_data_we_i(d_we),
        .wb_data_sel_i(d_sel), .wb_data_adr_i(d_adr), .wb_data_dat_mosi_i(d_dmo),
        .wb_data_dat_miso_o(d_dmi), .wb_data_ack_o(d_ack), .wb_data_err_o(d_err),
        .wb_mem_cyc_o(m_cyc), .wb_mem_stb_o(m_stb), .wb_mem_we_o(m_we),
        .wb_mem_sel_o(m_sel), .wb_mem_adr_o(m_adr), .wb_mem_dat_mosi_o(m_dmo),
        .wb_mem_dat_miso_i(m_dmi), .wb_mem_ack_i(m_ack), .wb_mem_err_i(m_err),
        .grant_out(grant), .timeout_out(tmo)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs();
        i_cyc = 0; i_stb = 0; i_we = 0; i_sel = 4'hF; i_adr = '0; i_dmo = '0;
        d_cyc = 0; d_stb = 0; d_we = 0; d_sel = 4'hF; d_adr = '0; d_dmo = '0;
        m_dmi = '0; m_ack = 0; m_err = 0;
    endtask

    // Hold reset for two cycles and release it on a falling edge.
    task automatic do_reset();
        rst = 0;
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        rst = 1;
    endtask

    task automatic test_reset();
        clear_inputs();
        i_cyc = 1; i_stb = 1; i_adr = 30'h3FF; m_ack = 1;
        rst = 0;
        @(negedge clk); @(negedge clk); #1;
        checks++;
        if ({grant, m_cyc, m_stb, m_we, m_sel, m_adr, m_dmo, i_ack, i_err, d_ack, d_err, tmo} !== '0) begin
            failures++;
            $display("FAIL reset_state: grant=%b cyc=%b stb=%b we=%b sel=%h adr=%h ack_i=%b tmo=%b, required all zero",
                     grant, m_cyc, m_stb, m_we, m_sel, m_adr, i_ack, tmo);
        end
    endtask

    task automatic test_streaming();
        do_reset();
        i_cyc = 1; i_stb = 1; i_adr = 30'h0; m_ack = 1;
        #1;
        checks++;
        if ({grant, m_cyc, i_ack} !== 4'b0) begin
            failures++;
            $display("FAIL stream_idle: grant=%b cyc=%b ack_i=%b, required 00 0 0", grant, m_cyc, i_ack);
        end
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk); #1;
            checks++;
            if ({grant, m_cyc, i_ack, d_ack, m_adr} !== {2'b01, 1'b1, 1'b1, 1'b0, 30'h0}) begin
                failures++;
                $display("FAIL stream_cycle%0d: grant=%b cyc=%b ack_i=%b ack_d=%b adr=%h, required 01 1 1 0 0",
                         k, grant, m_cyc, i_ack, d_ack, m_adr);
            end
        end
    endtask

    task automatic test_tie();
        do_reset();
        i_cyc = 1; i_stb = 1; i_adr = 30'h10;
        d_cyc = 1; d_stb = 1; d_adr = 30'h400;
        m_ack = 1; m_dmi = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (grant !== 2'b00) begin
            failures++;
            $display("FAIL tie_idle: grant=%b, required 00", grant);
        end
        @(negedge clk); #1;
        checks++;
        if ({grant, i_ack, d_ack, m_adr} !== {2'b01, 1'b1, 1'b0, 30'h10}) begin
            failures++;
            $display("FAIL tie_first_i: grant=%b ack_i=%b ack_d=%b adr=%h, required 01 1 0 010", grant, i_ack, d_ack, m_adr);
        end
        @(negedge clk); #1;
        checks++;
        if ({grant, i_ack, d_ack, m_adr, d_dmi} !== {2'b10, 1'b0, 1'b1, 30'h400, 32'hDEAD_BEEF}) begin
            failures++;
            $display("FAIL tie_then_d: grant=%b ack_i=%b ack_d=%b adr=%h dat=%h, required 10 0 1 400 deadbeef",
                     grant, i_ack, d_ack, m_adr, d_dmi);
        end
        @(negedge clk); #1;
        checks++;
        if (grant !== 2'b01) begin
            failures++;
            $display("FAIL tie_regrant_i: grant=%b, required 01", grant);
        end
    endtask

    task automatic test_err();
        do_reset();
        d_cyc = 1; d_stb = 1; d_adr = 30'h55;
        @(negedge clk);
        i_cyc = 1; i_stb = 1; m_err = 1;
        #1;
        checks++;
        if ({grant, d_err, i_err, d_ack} !== {2'b10, 1'b1, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL err_to_d: grant=%b err_d=%b err_i=%b ack_d=%b, required 10 1 0 0", grant, d_err, i_err, d_ack);
        end
        @(negedge clk);
        m_err = 0;
        #1;
        checks++;
        if (grant !== 2'b01) begin
            failures++;
            $display("FAIL err_next_i: grant=%b, required 01", grant);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        i_cyc = 1; i_stb = 1; i_adr = 30'h77;
        for (int g = 1; g <= T + 1; g++) begin
            @(negedge clk); #1;
            checks++;
            if (g <= T) begin
                if ({grant, m_cyc, i_err, tmo} !== {2'b01, 1'b1, 1'b0, 1'b0}) begin
                    failures++;
                    $display("FAIL timeout_wait%0d: grant=%b cyc=%b err_i=%b tmo=%b, required 01 1 0 0", g, grant, m_cyc, i_err, tmo);
                end
            end else if ({grant, m_cyc, i_err, tmo} !== {2'b01, 1'b0, 1'b1, 1'b1}) begin
                failures++;
                $display("FAIL timeout_fire: grant=%b cyc=%b err_i=%b tmo=%b, required 01 0 1 1", grant, m_cyc, i_err, tmo);
            end
        end
        @(negedge clk);
        i_cyc = 0; i_stb = 0; m_ack = 1;
        #1;
        checks++;
        if ({i_ack, i_err, m_cyc, tmo} !== 4'b0) begin
            failures++;
            $display("FAIL timeout_late_ack: ack_i=%b err_i=%b cyc=%b tmo=%b, required 0 0 0 0", i_ack, i_err, m_cyc, tmo);
        end
        @(negedge clk); #1;
        checks++;
        if ({grant, i_ack} !== 3'b000) begin
            failures++;
            $display("FAIL timeout_idle: grant=%b ack_i=%b, required 00 0", grant, i_ack);
        end
    endtask

    task automatic test_drop();
        do_reset();
        i_cyc = 1; i_stb = 1; i_adr = 30'h111;
        d_cyc = 1; d_stb = 1; d_adr = 30'h222;
        @(negedge clk); #1;
        checks++;
        if ({grant, m_adr, m_cyc} !== {2'b01, 30'h111, 1'b1}) begin
            failures++;
            $display("FAIL drop_owner_i: grant=%b adr=%h cyc=%b, required 01 111 1", grant, m_adr, m_cyc);
        end
        @(negedge clk);
        i_cyc = 0; i_stb = 0; m_ack = 1;
        #1;
        checks++;
        if ({m_cyc, i_ack, i_err} !== 3'b000) begin
            failures++;
            $display("FAIL drop_release: cyc=%b ack_i=%b err_i=%b, required 0 0 0", m_cyc, i_ack, i_err);
        end
        @(negedge clk);
        m_ack = 0;
        #1;
        checks++;
        if ({grant, m_cyc, m_adr, i_ack, i_err} !== {2'b10, 1'b1, 30'h222, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL drop_switch_d: grant=%b cyc=%b adr=%h ack_i=%b err_i=%b, required 10 1 222 0 0",
                     grant, m_cyc, m_adr, i_ack, i_err);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        i_cyc = 1; i_stb = 1; i_adr = 30'h9;
        @(negedge clk); #1;
        checks++;
        if ({grant, m_cyc} !== 3'b011) begin
            failures++;
            $display("FAIL areset_pre: grant=%b cyc=%b, required 01 1", grant, m_cyc);
        end
        #2;
        rst = 0; m_ack = 1;
        #1;
        checks++;
        if ({grant, m_cyc, m_stb, i_ack} !== 5'b0) begin
            failures++;
            $display("FAIL areset_drop: grant=%b cyc=%b stb=%b ack_i=%b, required 00 0 0 0", grant, m_cyc, m_stb, i_ack);
        end
        d_cyc = 1; d_stb = 1;
        @(negedge clk);
        m_ack = 0; rst = 1;
        #1;
        checks++;
        if (grant !== 2'b00) begin
            failures++;
            $display("FAIL areset_idle: grant=%b, required 00", grant);
        end
        @(negedge clk); #1;
        checks++;
        if (grant !== 2'b01) begin
            failures++;
            $display("FAIL areset_tie_i: grant=%b, required 01", grant);
        end
    endtask

    // Reference model: the owner is 0 (none), 1 (I) or 2 (D). A transfer is a run of owner cycles
    // ending on ack/err, on T stalled strobe cycles, or when the owner lets go of cyc.
    function automatic int pick(input bit ri, input bit rd, input int last);
        if (ri && rd) return (last == 1) ? 2 : 1;
        if (ri)       return 1;
        if (rd)       return 2;
        return 0;
    endfunction

    task automatic test_random(input int n);
        int          owner, last, waited;
        bit          ri, rd, oc, os, live, fire, done;
        logic [8:0]  exp_v, got_v;
        logic [34:0] exp_bus;
        do_reset();
        owner = 0; last = 2; waited = 0;
        for (int c = 0; c < n; c++) begin
            i_cyc = ($urandom_range(0, 9) < 7); i_stb = i_cyc & ($urandom_range(0, 3) != 0);
            d_cyc = ($urandom_range(0, 9) < 6); d_stb = d_cyc & ($urandom_range(0, 3) != 0);
            i_we = 1'($urandom); d_we = 1'($urandom);
            i_sel = 4'($urandom); d_sel = 4'($urandom);
            i_adr = 30'($urandom); d_adr = 30'($urandom);
            i_dmo = $urandom; d_dmo = $urandom; m_dmi = $urandom;
            m_ack = ($urandom_range(0, 3) == 0);
            m_err = !m_ack && ($urandom_range(0, 15) == 0);
            #1;
            ri   = i_cyc && i_stb;
            rd   = d_cyc && d_stb;
            oc   = (owner == 1) ? i_cyc : (owner == 2) ? d_cyc : 1'b0;
            os   = (owner == 1) ? i_stb : (owner == 2) ? d_stb : 1'b0;
            live = (owner != 0) && oc;
            fire = live && os && !m_ack && !m_err && (waited == T);
            done = live && (m_ack || m_err || fire);
            exp_v = {2'(owner), live && !fire, live && os && !fire,
                     owner == 1 && live && m_ack, owner == 1 && live && (m_err || fire),
                     owner == 2 && live && m_ack, owner == 2 && live && (m_err || fire), fire};
            got_v = {grant, m_cyc, m_stb, i_ack, i_err, d_ack, d_err, tmo};
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("FAIL random_ctrl cycle %0d: got %b required %b (grant,cyc,stb,ack_i,err_i,ack_d,err_d,tmo)", c, got_v, exp_v);
            end
            checks++;
            if ({i_dmi, d_dmi} !== {m_dmi, m_dmi}) begin
                failures++;
                $display("FAIL random_miso cycle %0d: got %h/%h required %h", c, i_dmi, d_dmi, m_dmi);
            end
            if (live) begin
                exp_bus = (owner == 1) ? {i_we, i_sel, i_adr} : {d_we, d_sel, d_adr};
                checks++;
                if ({m_we, m_sel, m_adr} !== exp_bus) begin
                    failures++;
                    $display("FAIL random_bus cycle %0d: got %h required %h", c, {m_we, m_sel, m_adr}, exp_bus);
                end
            end
            @(posedge clk);
            if (owner == 0) begin
                owner = pick(ri, rd, last); waited = 0;
            end else if (!oc) begin
                owner = pick(ri && owner != 1, rd && owner != 2, last); waited = 0;
            end else if (done) begin
                last = owner; owner = pick(ri, rd, last); waited = 0;
            end else if (os && waited < T) begin
                waited++;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_tie();
        test_err();
        test_timeout();
        test_drop();
        test_async_reset();
        test_random(800);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
